// File: rtl/fft_pkg.sv
// Shared definitions for the FFT stage sequencer.
//   state_e        : sequencer FSM states
//   PP_INPLACE     : memory mode, single bank updated in place
//   PP_PINGPONG    : memory mode, alternate between two banks per stage
//   clog2()        : ceiling log2 usable in parameter expressions
package fft_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StDrain,
      StDone
   } state_e;

   localparam logic PP_INPLACE  = 1'b0;
   localparam logic PP_PINGPONG = 1'b1;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Valid-tagged shift register that re-times butterfly read information into
// write-back information.
//   clk_i   : clock, rising edge
//   clr_ni  : synchronous active-low clear of every stage (valid and data)
//   valid_i : entry valid at the input
//   data_i  : entry payload
//   valid_o : valid tag, DEPTH cycles after valid_i
//   data_o  : payload, DEPTH cycles after data_i
module fft_delay_line #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 3
) (
   input  logic             clk_i,
   input  logic             clr_ni,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   logic [DEPTH-1:0]            valid_q, valid_d;
   logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;

   always_comb begin
      valid_d    = valid_q;
      data_d     = data_q;
      valid_d[0] = valid_i;
      data_d[0]  = data_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         valid_d[i] = valid_q[i-1];
         data_d[i]  = data_q[i-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!clr_ni) begin
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q[DEPTH-1];
   assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Control core for an in-place radix-2 DIT FFT of 2^LOG2N points. Issues
// butterfly read address pairs plus twiddle indices and returns the matching
// write-back addresses BFLY_LAT cycles later.
//   CLOCK_50               : clock, rising edge
//   RST                    : synchronous reset, active-low
//   start                  : start request, honoured only while idle
//   pp_mode / pipe_en      : memory mode / issue mode, latched at start
//   stall                  : freezes issue while high
//   busy / done            : run in progress / one-cycle completion pulse
//   stage                  : current stage index
//   rd_en, rd_addr_a/b     : butterfly read strobe and address pair
//   tw_idx, rd_bank        : twiddle ROM index, bank being read
//   wr_en, wr_addr_a/b     : write-back strobe and address pair
//   wr_bank                : bank being written
//   res_bank               : bank holding the final result (valid from done)
module fft_stage_sequencer
   import fft_pkg::*;
#(
   parameter int unsigned LOG2N    = 4,
   parameter int unsigned BFLY_LAT = 3,
   parameter int unsigned STG_W    = clog2(LOG2N + 1)
) (
   input  logic             CLOCK_50,
   input  logic             RST,
   input  logic             start,
   input  logic             pp_mode,
   input  logic             pipe_en,
   input  logic             stall,
   output logic             busy,
   output logic             done,
   output logic [STG_W-1:0] stage,
   output logic             rd_en,
   output logic [LOG2N-1:0] rd_addr_a,
   output logic [LOG2N-1:0] rd_addr_b,
   output logic [LOG2N-2:0] tw_idx,
   output logic             rd_bank,
   output logic             wr_en,
   output logic [LOG2N-1:0] wr_addr_a,
   output logic [LOG2N-1:0] wr_addr_b,
   output logic             wr_bank,
   output logic             res_bank
);

   localparam int unsigned B_W   = LOG2N - 1;
   localparam int unsigned HALF  = 1 << (LOG2N - 1);
   localparam int unsigned CNT_W = clog2(BFLY_LAT + 1);
   localparam int unsigned DL_W  = 2 * LOG2N + 1;

   localparam logic [B_W-1:0]   B_LAST   = B_W'(HALF - 1);
   localparam logic [STG_W-1:0] STG_LAST = STG_W'(LOG2N - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BFLY_LAT - 1);
   // Ping-pong flips banks every stage, so the result lands on parity of LOG2N.
   localparam logic             RES_PP   = 1'(LOG2N % 2);

   state_e           state_q, state_d;
   logic [STG_W-1:0] stage_q, stage_d;
   logic [B_W-1:0]   b_q, b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pp_q, pp_d;
   logic             pipe_q, pipe_d;
   logic             res_q, res_d;
   logic             stage_end;

   logic [LOG2N-1:0] b_ext, span, pos, grp, addr_a, addr_b;
   logic [B_W-1:0]   tw;
   logic             wbank_iss;
   logic [DL_W-1:0]  wb_data;

   // Butterfly address generation: insert a zero at bit 'stage' of b.
   always_comb begin
      b_ext  = LOG2N'(b_q);
      span   = LOG2N'(1) << stage_q;
      pos    = b_ext & (span - LOG2N'(1));
      grp    = b_ext >> stage_q;
      addr_a = (grp << (stage_q + STG_W'(1))) | pos;
      addr_b = addr_a + span;
      tw     = B_W'(pos << (STG_LAST - stage_q));
   end

   always_comb begin
      state_d   = state_q;
      stage_d   = stage_q;
      b_d       = b_q;
      cnt_d     = cnt_q;
      pp_d      = pp_q;
      pipe_d    = pipe_q;
      res_d     = res_q;
      stage_end = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               pp_d    = pp_mode;
               pipe_d  = pipe_en;
               stage_d = '0;
               b_d     = '0;
               cnt_d   = '0;
               res_d   = 1'b0;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (!stall) begin
               cnt_d = '0;
               if (!pipe_q) begin
                  state_d = StWait;
               end else if (b_q == B_LAST) begin
                  state_d = StDrain;
               end else begin
                  b_d = b_q + B_W'(1);
               end
            end
         end
         StWait: begin
            if (cnt_q == CNT_LAST) begin
               if (b_q == B_LAST) begin
                  stage_end = 1'b1;
               end else begin
                  b_d     = b_q + B_W'(1);
                  state_d = StIssue;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StDrain: begin
            if (cnt_q == CNT_LAST) begin
               stage_end = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // The last write of the stage has retired, so the next stage may read.
      if (stage_end) begin
         if (stage_q == STG_LAST) begin
            state_d = StDone;
            res_d   = (pp_q == PP_PINGPONG) ? RES_PP : 1'b0;
         end else begin
            stage_d = stage_q + STG_W'(1);
            b_d     = '0;
            state_d = StIssue;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!RST) begin
         state_q <= StIdle;
         stage_q <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         pp_q    <= PP_INPLACE;
         pipe_q  <= 1'b0;
         res_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         pp_q    <= pp_d;
         pipe_q  <= pipe_d;
         res_q   <= res_d;
      end
   end

   // Read-side outputs are zeroed whenever no read issues.
   always_comb begin
      busy      = (state_q != StIdle);
      done      = (state_q == StDone);
      stage     = stage_q;
      res_bank  = res_q;
      rd_en     = (state_q == StIssue) && !stall;
      rd_addr_a = rd_en ? addr_a : '0;
      rd_addr_b = rd_en ? addr_b : '0;
      tw_idx    = rd_en ? tw : '0;
      rd_bank   = rd_en && (pp_q == PP_PINGPONG) && stage_q[0];
      wbank_iss = rd_en && (pp_q == PP_PINGPONG) && !stage_q[0];
   end

   fft_delay_line #(
      .WIDTH(DL_W),
      .DEPTH(BFLY_LAT)
   ) u_wb_delay (
      .clk_i  (CLOCK_50),
      .clr_ni (RST),
      .valid_i(rd_en),
      .data_i ({rd_addr_a, rd_addr_b, wbank_iss}),
      .valid_o(wr_en),
      .data_o (wb_data)
   );

   assign {wr_addr_a, wr_addr_b, wr_bank} = wb_data;

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Parametrised control core for the FFT pipeline. Sequences an in-place radix-2 DIT FFT of N = 2^LOG2N points over LOG2N stages.
- Issues butterfly read-address pairs and twiddle indices to the datapath. Returns matching write-back addresses exactly BFLY_LAT cycles later.
- Generalises the fixed memory-switch / pipeline-switch behaviour into run-time modes:
  - memory mode: in-place single bank, or ping-pong between two banks;
  - issue mode: pipelined (one butterfly per cycle) or single-issue;
  - adds a stall input and a start/busy/done handshake.

Parameters:
- LOG2N, 4, log2 of FFT length; N = 2^LOG2N, N/2 butterflies per stage; legal range 2..12.
- BFLY_LAT, 3, butterfly datapath latency in cycles, read to write-back; legal range 1..16.
- STG_W, derived clog2(LOG2N+1), width of the stage counter/output.

Ports:
- CLOCK_50  in  1  sole clock, rising edge.
- RST  in  1  synchronous reset, active-low.
- start  in  1  start request; sampled only in IDLE.
- pp_mode  in  1  0 = in-place single bank, 1 = ping-pong banks; latched at start.
- pipe_en  in  1  1 = pipelined issue, 0 = single-issue; latched at start.
- stall  in  1  freezes issue while high.
- busy  out  1  high from start acceptance through the done cycle.
- done  out  1  one-cycle pulse, final stage fully written.
- stage  out  STG_W  current stage index.
- rd_en  out  1  butterfly read-issue strobe.
- rd_addr_a  out  LOG2N  top input address.
- rd_addr_b  out  LOG2N  bottom input address.
- tw_idx  out  LOG2N-1  twiddle ROM index.
- rd_bank  out  1  bank read.
- wr_en  out  1  write-back strobe.
- wr_addr_a  out  LOG2N  write-back top address.
- wr_addr_b  out  LOG2N  write-back bottom address.
- wr_bank  out  1  bank written.
- res_bank  out  1  bank holding the final result; valid when done = 1, held until next start.

Behaviour:
- Reset (RST low at a rising edge):
  - State goes to IDLE.
  - All outputs 0, counters 0, latched modes 0.
  - Delay-line valid bits are cleared, so no wr_en ever appears after a reset, including a reset mid-run.
- States:
  - IDLE: start = 1 latches modes, clears stage and butterfly index b, then goes to ISSUE. start is ignored whenever busy = 1.
  - ISSUE:
    - If stall = 0: rd_en = 1 with addresses for (stage, b).
    - If stall = 1: rd_en = 0 and counters hold; in-flight writes still retire.
    - Pipelined: b increments every unstalled cycle. When b = N/2-1 issues, go to DRAIN.
    - Single-issue: after each issue, go to WAIT.
  - WAIT (single-issue only):
    - Lasts BFLY_LAT cycles; wr_en for that butterfly fires in the last WAIT cycle.
    - Then: if b < N/2-1, b++ and return to ISSUE; else go to stage-end.
  - DRAIN (pipelined): lasts BFLY_LAT cycles; the last wr_en of the stage fires in the final DRAIN cycle.
  - Stage-end (shared by WAIT and DRAIN):
    - If stage < LOG2N-1: stage++, b = 0, go to ISSUE.
    - Else: go to DONE.
  - DONE: lasts one cycle with done = 1 and busy = 1, then goes to IDLE.
- Address arithmetic for stage s, butterfly b (all unsigned):
  - span = 1 << s;
  - pos = b & (span-1);
  - grp = b >> s;
  - rd_addr_a = (grp << (s+1)) | pos;
  - rd_addr_b = rd_addr_a + span;
  - tw_idx = pos << (LOG2N-1-s).
- Write-back: wr_en, wr_addr_a, wr_addr_b and wr_bank are exactly the rd_* values delayed by BFLY_LAT cycles, through a valid-tagged shift register.
- Hazard rule: the next stage's first read is never issued before the cycle after the previous stage's last write.
- Banks:
  - In-place: rd_bank = wr_bank = 0 and res_bank = 0.
  - Ping-pong: rd_bank = stage[0], wr_bank = ~stage[0] (delayed with the write), and res_bank = LOG2N[0].
- Timing with no stall, first rd_en at cycle 1:
  - Pipelined: each stage takes N/2 + BFLY_LAT cycles; done is asserted at LOG2N*(N/2+BFLY_LAT)+1.
  - Single-issue: done is asserted at LOG2N*(N/2)*(1+BFLY_LAT)+1.
  - Each stalled ISSUE cycle adds exactly 1 cycle.
- Changes to pp_mode or pipe_en mid-run have no effect.

Decomposition:
- Shared package fft_pkg holds:
  - state enum: IDLE, ISSUE, WAIT, DRAIN, DONE;
  - the clog2 function;
  - mode encodings PP_INPLACE = 0, PP_PINGPONG = 1.
- Sub-module fft_delay_line, parametrised on WIDTH and DEPTH (= BFLY_LAT). It is a valid-tagged shift register with synchronous active-low clear, carrying {valid, addr_a, addr_b, bank}.

Test Plan:
- Pipelined in-place run (LOG2N = 4, BFLY_LAT = 3, start pulse):
  - stage-0 reads (0,1), (2,3)…; stage-3 reads (0,8), (1,9)… with tw_idx 0..7;
  - each wr_en trails its rd_en by 3 cycles;
  - done at cycle 45 (first rd_en = cycle 1); res_bank = 0.
- Single-issue run (pipe_en = 0, same parameters):
  - rd_en is never high in two consecutive cycles;
  - every wr_en lands in the 3rd cycle after its rd_en;
  - done at cycle 129.
- Ping-pong run (pp_mode = 1):
  - rd_bank/wr_bank = 0/1, 1/0, 0/1, 1/0 across stages 0-3;
  - res_bank = 0 at done; LOG2N = 3 build gives res_bank = 1.
- Stall, pipelined: hold stall high for 2 cycles at stage 1, b = 3:
  - no rd_en in those cycles and b holds at 3;
  - in-flight wr_en still fire;
  - done at cycle 47.
- Reset mid-operation: drop RST for one cycle during stage 2, with 3 writes in flight:
  - next cycle: busy = 0, rd_en = 0, wr_en = 0 for ≥ BFLY_LAT cycles;
  - a fresh start then reproduces the first scenario exactly.
- start asserted during busy and at DONE: ignored. start in the cycle after DONE is accepted, and pipe_en toggled mid-run does not change timing.
